// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch path: opcodes, reset vector and fetch FSM encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection for the fetch stage: jr > j/jal > taken branch > PC+4.
module fetch_next_pc #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [25:0]           instr_low,
  input  logic                  branch_eq,
  input  logic                  branch_ne,
  input  logic                  jump_signal,
  input  logic                  jump_reg,
  input  logic                  zero,
  input  logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  redirect,
  output logic                  addr_err
);

  logic [DATA_WIDTH-1:0] branch_off;
  logic                  taken;

  assign pc_plus4   = pc + DATA_WIDTH'(4);
  assign branch_off = {{14{instr_low[15]}}, instr_low[15:0], 2'b00};
  assign taken      = (branch_eq & zero) | (branch_ne & ~zero);

  always_comb begin
    next_pc  = pc_plus4;
    redirect = 1'b0;
    addr_err = 1'b0;
    if (jump_reg) begin
      // jr target is forced word-aligned; misalignment is flagged, not trapped
      next_pc  = {rs_data[DATA_WIDTH-1:2], 2'b00};
      redirect = 1'b1;
      addr_err = |rs_data[1:0];
    end else if (jump_signal) begin
      next_pc  = {pc_plus4[DATA_WIDTH-1:DATA_WIDTH-4], instr_low, 2'b00};
      redirect = 1'b1;
    end else if (taken) begin
      next_pc  = pc_plus4 + branch_off;
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches from variable-latency imem, holds the word for decode.
// Optional FETCH_PERF_CNT_EN adds retire and redirect counters.
module instruction_fetch_unit
  import mips_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  output logic                  imem_req_o,
  input  logic                  imem_ack_i,
  input  logic [DATA_WIDTH-1:0] imem_rdata_i,
  input  logic                  branch_eq_i,
  input  logic                  branch_ne_i,
  input  logic                  jump_signal_i,
  input  logic                  jump_reg_i,
  input  logic                  zero_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic                  stall_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [5:0]            opcode_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o,
  output logic                  instr_valid_o,
  output logic                  redirect_o,
  output logic                  addr_err_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           instr_count_o,
  output logic [31:0]           redirect_count_o,
`endif
  output fetch_state_e          fsm_state_o
);

  // Handshake: imem_req_o stays high with imem_addr_o stable for the whole FETCH
  // state; the word is taken on the first edge where imem_ack_i=1 (may be the
  // same cycle req rises). Acks in any other state are dropped.

  fetch_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, instr_q, next_pc;
  logic                  redirect_q, addr_err_q;
  logic                  redirect_c, addr_err_c;
  logic                  capture, retire;

  fetch_next_pc #(.DATA_WIDTH(DATA_WIDTH)) u_next_pc (
    .pc          (pc_q),
    .instr_low   (instr_q[25:0]),
    .branch_eq   (branch_eq_i),
    .branch_ne   (branch_ne_i),
    .jump_signal (jump_signal_i),
    .jump_reg    (jump_reg_i),
    .zero        (zero_i),
    .rs_data     (rs_data_i),
    .pc_plus4    (pc_plus4_o),
    .next_pc     (next_pc),
    .redirect    (redirect_c),
    .addr_err    (addr_err_c)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_RST:   state_d = ST_FETCH;
      ST_FETCH: begin
        capture = imem_ack_i;
        if (imem_ack_i) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        retire = ~stall_i;
        if (!stall_i) state_d = ST_FETCH;
      end
      default:  state_d = ST_RST;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RST;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      redirect_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      redirect_q <= retire & redirect_c;
      addr_err_q <= retire & addr_err_c;
      if (capture) instr_q <= imem_rdata_i;
      if (retire)  pc_q    <= next_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_count_o    <= '0;
      redirect_count_o <= '0;
    end else if (retire) begin
      instr_count_o <= instr_count_o + 32'd1;
      if (redirect_c) redirect_count_o <= redirect_count_o + 32'd1;
    end
  end
`endif

  assign imem_addr_o   = pc_q;
  assign imem_req_o    = (state_q == ST_FETCH);
  assign instr_valid_o = (state_q == ST_EXEC);
  assign instr_o       = instr_q;
  assign opcode_o      = instr_q[DATA_WIDTH-1 -: 6];
  assign redirect_o    = redirect_q;
  assign addr_err_o    = addr_err_q;
  assign fsm_state_o   = state_q;

endmodule
